instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder: packs RISC-V RV32I fields into 32-bit instruction words and streams them into instruction memory through its write port.
- Sequential address counter and capacity tracking; used by the boot/program-load path and by benches that build programs.
- One pipeline stage: accept, encode and range-check, then write to imem.

Parameters:
- ADDR_W, 32, imem byte-address width
- BASE_ADDR, 32'h0000_0000, first write address (word aligned)
- DEPTH, 256, max words per load session (1..65535)

Ports:
Interface: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin/restart a load session at BASE_ADDR
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept
- fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- opcode  in  7  instr[6:0]
- rd  in  5  instr[11:7]
- rs1  in  5  instr[19:15]
- rs2  in  5  instr[24:20]
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25] (R only)
- imm  in  32  full signed immediate value (U: full value, low 12 bits must be 0)
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  ADDR_W  byte address of the write
- imem_wdata  out  32  encoded instruction
- count  out  16  words written this session
- full  out  1  count == DEPTH
- err_valid  out  1  one-cycle error pulse
- err_code  out  2  0=none 1=imm out of range 2=imm misaligned 3=illegal fmt

Behaviour:
- FSM states: IDLE, RUN, FULL. Reset -> IDLE.
- Reset values: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, err_valid=0, err_code=0.
- IDLE: in_ready=0. When start=1, next state is RUN, the write pointer is set to BASE_ADDR, and count=0.
- RUN: in_ready=1 only when start=0. A transfer occurs on in_valid&in_ready.
- start=1 in any state clears the pointer and count and goes to RUN. A bundle presented in the same cycle is not accepted.
- Encoding (standard RV32I):
  - R = {funct7,rs2,rs1,funct3,rd,opcode}
  - I = {imm[11:0],rs1,funct3,rd,opcode}
  - S = {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B = {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U = {imm[31:12],rd,opcode}
  - J = {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
  - Fields unused by a format are ignored.
- Range checks:
  - I/S: -2048..2047.
  - B: -4096..4094, and imm[0] must be 0.
  - J: -1048576..1048574, and imm[0] must be 0.
  - U: imm[11:0] must be 0, else code 2.
  - Range failure takes priority over misalignment.
- Latency: on an accepted good bundle, in the next cycle imem_we=1, imem_addr=pointer, imem_wdata=encoding. The pointer then advances by 4 and count by 1. Throughput is 1 word/cycle.
- Accepted bad bundle: next cycle err_valid=1 and err_code set. No write, and pointer/count unchanged. err_code holds its value until the next error or reset.
- When the write makes count reach DEPTH: full=1 and the state goes to FULL. in_ready drops in the same cycle as that write strobe, so no bundle is accepted at count==DEPTH. FULL holds until start or rst.
- Pointer arithmetic is modulo 2^ADDR_W; wrap is not checked.
- rst mid-session: any pending write or error in the pipeline stage is discarded (no strobe). All state returns to reset values.
- Round-trip requirement: feeding imem_wdata through the decoder must return the same opcode/rd/rs1/rs2/funct3/funct7, and for I format the same sign-extended imm.

Test Plan:
- rst, then start, then I fmt (op 0x13, rd=1, rs1=0, f3=0, imm=5) -> next cycle imem_we=1, addr 0x0, wdata 0x00500093, count=1.
- Back-to-back R add (op 0x33, rd=3, rs1=1, rs2=2) then S sw (op 0x23, f3=2, rs1=1, rs2=2, imm=8) -> 0x002081B3 at 0x4, then 0x0020A423 at 0x8 on consecutive cycles.
- B beq (op 0x63, rs1=1, rs2=2, imm=-8) -> 0xFE208CE3. U lui (op 0x37, rd=5, imm=0x12345000) -> 0x123452B7.
- Error cases:
  - I imm=2048 -> err_valid pulse, err_code=1, no imem_we, count unchanged.
  - B imm=3 -> err_code=2.
  - fmt=7 -> err_code=3.
- DEPTH=4: stream 6 bundles with in_valid held -> 4 writes (0x0..0xC), full=1, in_ready=0. Then start -> next write at 0x0 and count restarts from 0.
- Assert rst the cycle after acceptance -> no imem_we, count=0, state IDLE. start in the same cycle as in_valid -> bundle not accepted.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// RV32I field-bundle encoder that streams packed instruction words into imem.
// One registered stage: accept and range-check a bundle, then strobe the write or raise an error.
module instr_encoder_loader #(
    parameter int unsigned              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]        BASE_ADDR = '0,
    parameter int unsigned              DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [15:0]       count,
    output logic              full,
    output logic              err_valid,
    output logic [1:0]        err_code
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    localparam logic [2:0] F_R = 3'd0;
    localparam logic [2:0] F_I = 3'd1;
    localparam logic [2:0] F_S = 3'd2;
    localparam logic [2:0] F_B = 3'd3;
    localparam logic [2:0] F_U = 3'd4;
    localparam logic [2:0] F_J = 3'd5;

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_RANGE = 2'd1;
    localparam logic [1:0] E_ALIGN = 2'd2;
    localparam logic [1:0] E_FMT   = 2'd3;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              we_q;
    logic              err_q;
    logic [31:0]       enc;
    logic [1:0]        code;
    logic              accept;
    logic [15:0]       count_inc;
    logic signed [31:0] simm;

    assign simm      = imm;
    assign in_ready  = (state == S_RUN) && !start;
    assign accept    = in_valid && in_ready;
    assign count_inc = count + 16'd1;

    // Mask the registered strobes with rst so a write or error already in the
    // stage never appears on the outputs once reset is asserted.
    assign imem_we   = we_q  && !rst;
    assign err_valid = err_q && !rst;

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        enc  = '0;
        code = E_NONE;
        case (fmt)
            F_R: enc = {funct7, rs2, rs1, funct3, rd, opcode};
            F_I: begin
                enc = {imm[11:0], rs1, funct3, rd, opcode};
                if (simm < -32'sd2048 || simm > 32'sd2047) code = E_RANGE;
            end
            F_S: begin
                enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                if (simm < -32'sd2048 || simm > 32'sd2047) code = E_RANGE;
            end
            F_B: begin
                enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                // Out-of-range wins over an odd offset.
                if (simm < -32'sd4096 || simm > 32'sd4094) code = E_RANGE;
                else if (imm[0])                            code = E_ALIGN;
            end
            F_U: begin
                enc = {imm[31:12], rd, opcode};
                if (imm[11:0] != 12'd0) code = E_ALIGN;
            end
            F_J: begin
                enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                if (simm < -32'sd1048576 || simm > 32'sd1048574) code = E_RANGE;
                else if (imm[0])                                  code = E_ALIGN;
            end
            default: code = E_FMT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= BASE_ADDR;
            count      <= '0;
            full       <= 1'b0;
            we_q       <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            err_q      <= 1'b0;
            err_code   <= E_NONE;
        end else begin
            we_q  <= 1'b0;
            err_q <= 1'b0;
            if (start) begin
                state <= S_RUN;
                ptr   <= BASE_ADDR;
                count <= '0;
                full  <= 1'b0;
            end else if (accept) begin
                if (code != E_NONE) begin
                    err_q    <= 1'b1;
                    err_code <= code;
                end else begin
                    we_q       <= 1'b1;
                    imem_addr  <= ptr;
                    imem_wdata <= enc;
                    ptr        <= ptr + ADDR_W'(4);
                    count      <= count_inc;
                    // Stop accepting on the same edge that launches the last write.
                    if (count_inc == DEPTH_W) begin
                        full  <= 1'b1;
                        state <= S_FULL;
                    end
                end
            end
        end
    end

endmodule
